// File: rtl/fd1hz_divider_pkg.sv
// Shared timer-chain constants and types for the 1 Hz reference divider.
package timer_pkg;

  localparam int unsigned REF_HZ     = 32768;
  localparam int unsigned FD1HZ_BITS = 15;

  typedef logic [FD1HZ_BITS-1:0] div_cnt_t;

endpackage

// File: rtl/fd1hz_divider_if.sv
// Control/output bundle of the 1 Hz divider: active-low preset in, divided clock out.
interface fd1hz_divider_if;

  logic pr;
  logic out;

  modport master (output pr, input out);
  modport slave  (input pr, output out);

endinterface

// File: rtl/fd1hz_divider_tff_sync.sv
// One divider stage: toggle flip-flop with synchronous clear (dominant) and active-low preset.
module tff_sync (
  input  logic clk,
  input  logic clr,
  input  logic pr_n,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (clr)
      q <= 1'b0;
    else if (!pr_n)
      q <= 1'b1;
    else if (t)
      q <= ~q;
  end

endmodule

// File: rtl/fd1hz_divider.sv
// Ripple-free synchronous binary divider: DIV_BITS toggle stages, MSB is the 50 % duty output.
module fd1hz_divider
  import timer_pkg::*;
#(
  parameter int unsigned DIV_BITS = FD1HZ_BITS
) (
  input  logic              clk,
  input  logic              clr,
  fd1hz_divider_if.slave    bus
);

  logic [DIV_BITS-1:0] q;
  logic [DIV_BITS-1:0] t;

  for (genvar k = 0; k < DIV_BITS; k++) begin : g_stage
    // Stage k toggles only when every lower stage is 1, i.e. on the carry into bit k.
    if (k == 0) begin : g_lsb
      assign t[k] = 1'b1;
    end else begin : g_upper
      assign t[k] = &q[k-1:0];
    end

    tff_sync u_tff (
      .clk  (clk),
      .clr  (clr),
      .pr_n (bus.pr),
      .t    (t[k]),
      .q    (q[k])
    );
  end

  assign bus.out = q[DIV_BITS-1];

endmodule

// File: tb/tb_fd1hz_divider.sv
// Self-checking bench for fd1hz_divider: default 15-stage instance and a 4-stage instance.
module tb_fd1hz_divider;

  localparam int unsigned BIG_BITS = 15;
  localparam int unsigned SML_BITS = 4;
  localparam int unsigned BIG_MOD  = 1 << BIG_BITS;
  localparam int unsigned SML_MOD  = 1 << SML_BITS;

  logic clk = 1'b0;
  logic clr_big;
  logic clr_sml;

  int unsigned compared   = 0;
  int unsigned mismatched = 0;

  fd1hz_divider_if bif ();
  fd1hz_divider_if sif ();

  fd1hz_divider u_big (
    .clk (clk),
    .clr (clr_big),
    .bus (bif.slave)
  );

  fd1hz_divider #(.DIV_BITS(SML_BITS)) u_sml (
    .clk (clk),
    .clr (clr_sml),
    .bus (sif.slave)
  );

  always #5 clk = ~clk;

  // Reference model: the count as a plain integer, out is "count in upper half".
  int unsigned big_cnt = 0;
  int unsigned sml_cnt = 0;

  function automatic int unsigned next_cnt(int unsigned cnt, logic c, logic p, int unsigned modulus);
    if (c)       return 0;
    else if (!p) return modulus - 1;
    else         return (cnt + 1) % modulus;
  endfunction

  task automatic check(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic big_edge(input logic c, input logic p);
    clr_big = c;
    bif.pr  = p;
    @(posedge clk);
    #1;
    big_cnt = next_cnt(big_cnt, c, p, BIG_MOD);
    check("big_model", bif.out, logic'(big_cnt >= BIG_MOD / 2));
  endtask

  task automatic sml_edge(input logic c, input logic p);
    clr_sml = c;
    sif.pr  = p;
    @(posedge clk);
    #1;
    sml_cnt = next_cnt(sml_cnt, c, p, SML_MOD);
  endtask

  typedef struct {
    logic clr;
    logic pr;
    logic exp_out;
  } vec_t;

  vec_t vecs[22];

  task automatic big_tests();
    logic prev;
    int unsigned toggles;
    int unsigned highs;

    // Hold clear: output pinned low well past a half period.
    big_edge(1'b1, 1'b1);
    check("reset_out", bif.out, 1'b0);
    prev    = bif.out;
    toggles = 0;
    for (int i = 0; i < 17000; i++) begin
      big_edge(1'b1, 1'b1);
      if (bif.out !== prev) toggles++;
      prev = bif.out;
    end
    check("hold_clr_out", bif.out, 1'b0);
    compared++;
    if (toggles != 0) begin
      mismatched++;
      $display("FAIL hold_clr_toggles: got %0d expected 0", toggles);
    end

    // Clear beats preset, then a full period from zero.
    for (int i = 0; i < 3; i++) begin
      big_edge(1'b1, 1'b0);
      check("clr_priority", bif.out, 1'b0);
    end
    highs = 0;
    for (int e = 1; e <= 32768; e++) begin
      big_edge(1'b0, 1'b1);
      if (bif.out === 1'b1) highs++;
      if (e == 16383) check("run_low_16383", bif.out, 1'b0);
      if (e == 16384) check("run_rise_16384", bif.out, 1'b1);
      if (e == 32767) check("run_high_32767", bif.out, 1'b1);
      if (e == 32768) check("run_fall_32768", bif.out, 1'b0);
    end
    compared++;
    if (highs != 16384) begin
      mismatched++;
      $display("FAIL run_high_cycles: got %0d expected 16384", highs);
    end

    // Preset: high immediately, falls on first count, rises on edge 16385.
    big_edge(1'b0, 1'b0);
    check("preset_out", bif.out, 1'b1);
    for (int e = 1; e <= 16385; e++) begin
      big_edge(1'b0, 1'b1);
      if (e == 1)     check("preset_fall_1", bif.out, 1'b0);
      if (e == 16384) check("preset_low_16384", bif.out, 1'b0);
      if (e == 16385) check("preset_rise_16385", bif.out, 1'b1);
    end

    // Mid-count clear while high; next rise is 16384 edges after release.
    check("mid_before_clr", bif.out, 1'b1);
    big_edge(1'b1, 1'b1);
    check("mid_clr_out", bif.out, 1'b0);
    for (int e = 1; e <= 16384; e++) begin
      big_edge(1'b0, 1'b1);
      if (e == 16383) check("mid_low_16383", bif.out, 1'b0);
      if (e == 16384) check("mid_rise_16384", bif.out, 1'b1);
    end
  endtask

  task automatic sml_tests();
    logic c;
    logic p;

    vecs[0] = '{clr: 1'b1, pr: 1'b1, exp_out: 1'b0};
    for (int k = 1; k <= 16; k++)
      vecs[k] = '{clr: 1'b0, pr: 1'b1, exp_out: logic'(k >= 8 && k < 16)};
    vecs[17] = '{clr: 1'b0, pr: 1'b0, exp_out: 1'b1};
    vecs[18] = '{clr: 1'b0, pr: 1'b1, exp_out: 1'b0};
    vecs[19] = '{clr: 1'b1, pr: 1'b0, exp_out: 1'b0};
    vecs[20] = '{clr: 1'b1, pr: 1'b0, exp_out: 1'b0};
    vecs[21] = '{clr: 1'b0, pr: 1'b1, exp_out: 1'b0};

    for (int i = 0; i < 22; i++) begin
      sml_edge(vecs[i].clr, vecs[i].pr);
      check($sformatf("sml_vec%0d", i), sif.out, vecs[i].exp_out);
    end

    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(15, 0) == 0);
      p = ($urandom_range(7, 0) != 0);
      sml_edge(c, p);
      check("sml_random", sif.out, logic'(sml_cnt >= SML_MOD / 2));
    end
    clr_sml = 1'b1;
    sif.pr  = 1'b1;
  endtask

  initial begin
    clr_big = 1'b1;
    clr_sml = 1'b1;
    bif.pr  = 1'b1;
    sif.pr  = 1'b1;
    fork
      big_tests();
      sml_tests();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
